phase_error_meter: RTL and testbench

Multi-bit phase detector for the DPLL loop, the parametrised successor to the single-bit lead/lag detector. It synchronises the reference (A) and feedback (B) inputs and measures the signed distance between their rising edges in clk_i cycles. It emits one error sample per edge pair, with saturation and slip flags, for the downstream loop filter. Level lead/lag outputs keep the existing bang-bang semantics for legacy consumers.

---
 rtl/phase_error_meter.sv | 165 ++++++++++++++++
 tb/tb_phase_error_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_error_meter.sv
// Multi-bit phase detector: synchronises reference (A) and feedback (B) inputs and
// measures the signed distance between their rising edges in clk_i cycles.
module phase_error_meter #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    signalA_i,
    input  logic                    signalB_i,
    output logic signed [CNT_W-1:0] error_o,
    output logic                    valid_o,
    output logic                    sat_o,
    output logic                    forwarding_o,
    output logic                    slowing_o
);

    localparam int unsigned CW = CNT_W - 1;
    localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};
    localparam logic [CNT_W-1:0] ERR_POS = {1'b0, ERR_MAX};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] A_FIRST = 2'd1;
    localparam logic [1:0] B_FIRST = 2'd2;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   hist_a;
    logic                   hist_b;
    logic                   rise_a;
    logic                   rise_b;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             valid_nxt;
    logic             sat_nxt;
    logic [CNT_W-1:0] pos_cnt;
    logic [CNT_W-1:0] neg_cnt;
    logic [CNT_W-1:0] err_neg;

    // Input synchronisers with one history flop for rising-edge detection
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], signalA_i};
            sync_b <= {sync_b[SYNC_STAGES-2:0], signalB_i};
            hist_a <= sync_a[SYNC_STAGES-1];
            hist_b <= sync_b[SYNC_STAGES-1];
        end
    end

    assign rise_a  = sync_a[SYNC_STAGES-1] & ~hist_a;
    assign rise_b  = sync_b[SYNC_STAGES-1] & ~hist_b;
    assign pos_cnt = {1'b0, cnt};
    assign neg_cnt = -pos_cnt;
    assign err_neg = -ERR_POS;

    // Next state, counter and strobe generation
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = error_o;
        valid_nxt = 1'b0;
        sat_nxt   = 1'b0;
        if (!enable_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_a && rise_b) begin
                        err_nxt   = '0;
                        valid_nxt = 1'b1;
                    end else if (rise_a) begin
                        state_nxt = A_FIRST;
                        cnt_nxt   = CW'(1);
                    end else if (rise_b) begin
                        state_nxt = B_FIRST;
                        cnt_nxt   = CW'(1);
                    end
                end
                A_FIRST: begin
                    if (rise_b) begin
                        err_nxt   = pos_cnt;
                        valid_nxt = 1'b1;
                        if (rise_a) begin
                            cnt_nxt = CW'(1);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (rise_a) begin
                        err_nxt   = ERR_POS;
                        valid_nxt = 1'b1;
                        sat_nxt   = 1'b1;
                        cnt_nxt   = CW'(1);
                    end else if (cnt == ERR_MAX) begin
                        err_nxt   = ERR_POS;
                        valid_nxt = 1'b1;
                        sat_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                B_FIRST: begin
                    if (rise_a) begin
                        err_nxt   = neg_cnt;
                        valid_nxt = 1'b1;
                        if (rise_b) begin
                            cnt_nxt = CW'(1);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (rise_b) begin
                        err_nxt   = err_neg;
                        valid_nxt = 1'b1;
                        sat_nxt   = 1'b1;
                        cnt_nxt   = CW'(1);
                    end else if (cnt == ERR_MAX) begin
                        err_nxt   = err_neg;
                        valid_nxt = 1'b1;
                        sat_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; lead flags decode the next state
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            error_o      <= '0;
            valid_o      <= 1'b0;
            sat_o        <= 1'b0;
            forwarding_o <= 1'b0;
            slowing_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            error_o      <= err_nxt;
            valid_o      <= valid_nxt;
            sat_o        <= sat_nxt;
            forwarding_o <= (state_nxt == B_FIRST);
            slowing_o    <= (state_nxt == A_FIRST);
        end
    end

endmodule

// File: tb/tb_phase_error_meter.sv
// Bench for phase_error_meter: event-time reference model checked every cycle,
// plus directed scenarios with hand-computed strobe values.
module tb_phase_error_meter;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SYNC    = 2;
    localparam int          ERR_MAX = 127;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    logic sig_a   = 1'b0;
    logic sig_b   = 1'b0;
    logic signed [CNT_W-1:0] error;
    logic valid;
    logic sat;
    logic fwd;
    logic slow;

    phase_error_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .enable_i    (enable),
        .signalA_i   (sig_a),
        .signalB_i   (sig_b),
        .error_o     (error),
        .valid_o     (valid),
        .sat_o       (sat),
        .forwarding_o(fwd),
        .slowing_o   (slow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lead = +1 (A leads), -1 (B leads), 0 (none); t0 = window start cycle
    int m_lead  = 0;
    int m_t0    = 0;
    int m_cyc   = 0;
    int m_err   = 0;
    bit m_valid = 1'b0;
    bit m_sat   = 1'b0;
    bit ha[SYNC+1];
    bit hb[SYNC+1];

    always @(posedge clk or negedge reset_n) begin : model
        bit ra, rb, closing, again;
        int d;
        if (!reset_n) begin
            m_lead = 0; m_err = 0; m_valid = 1'b0; m_sat = 1'b0;
            for (int i = 0; i <= SYNC; i++) begin ha[i] = 1'b0; hb[i] = 1'b0; end
        end else begin
            m_cyc++;
            ra = ha[SYNC-1] & ~ha[SYNC];
            rb = hb[SYNC-1] & ~hb[SYNC];
            for (int i = SYNC; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
            ha[0] = sig_a;
            hb[0] = sig_b;
            m_valid = 1'b0;
            m_sat   = 1'b0;
            d = m_cyc - m_t0;
            if (!enable) begin
                m_lead = 0;
            end else if (m_lead == 0) begin
                if (ra && rb) begin m_err = 0; m_valid = 1'b1; end
                else if (ra) begin m_lead = 1;  m_t0 = m_cyc; end
                else if (rb) begin m_lead = -1; m_t0 = m_cyc; end
            end else begin
                closing = (m_lead > 0) ? rb : ra;
                again   = (m_lead > 0) ? ra : rb;
                if (closing) begin
                    m_err = m_lead * d; m_valid = 1'b1;
                    if (again) m_t0 = m_cyc; else m_lead = 0;
                end else if (again) begin
                    m_err = m_lead * ERR_MAX; m_valid = 1'b1; m_sat = 1'b1; m_t0 = m_cyc;
                end else if (d == ERR_MAX) begin
                    m_err = m_lead * ERR_MAX; m_valid = 1'b1; m_sat = 1'b1; m_lead = 0;
                end
            end
        end
    end

    int log_err[$];
    bit log_sat[$];
    int slow_cycles = 0;
    int fwd_cycles  = 0;

    // Per-cycle comparison against the model, plus strobe/lead statistics
    always @(negedge clk) begin
        check("error_o", 32'(error), 32'(m_err));
        check("valid_o", 32'(valid), 32'(m_valid));
        check("sat_o", 32'(sat), 32'(m_valid ? m_sat : 1'b0));
        check("slowing_o", 32'(slow), 32'(m_lead > 0));
        check("forwarding_o", 32'(fwd), 32'(m_lead < 0));
        if (valid === 1'b1) begin log_err.push_back(int'(error)); log_sat.push_back(sat); end
        if (slow === 1'b1) slow_cycles++;
        if (fwd === 1'b1) fwd_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_err.delete();
        log_sat.delete();
        slow_cycles = 0;
        fwd_cycles  = 0;
    endtask

    task automatic check_strobe(input string name, input int idx, input int e, input bit s);
        if (idx < log_err.size()) begin
            check({name, "_err"}, 32'(log_err[idx]), 32'(e));
            check({name, "_sat"}, 32'(log_sat[idx]), 32'(s));
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: strobe %0d missing, expected error %0d", name, idx, e);
        end
    endtask

    initial begin
        int p, len;
        // Reset held with toggling inputs, then release with static inputs
        tick(1);
        for (int i = 0; i < 6; i++) begin
            sig_a = i[0]; sig_b = ~i[0]; tick(1);
        end
        @(negedge clk);
        check("rst_error", 32'(error), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_leads", 32'({fwd, slow, sat}), 0);
        sig_a = 1'b0; sig_b = 1'b0; enable = 1'b1;
        tick(1);
        reset_n = 1'b1;
        clr_log();
        tick(12);
        check("post_rst_strobes", 32'(log_err.size()), 0);

        // A leads by 5
        clr_log();
        sig_a = 1'b1; tick(5); sig_b = 1'b1; tick(8);
        check("lead_a_count", 32'(log_err.size()), 1);
        check_strobe("lead_a", 0, 5, 1'b0);
        check("lead_a_slow_cycles", 32'(slow_cycles), 5);
        check("lead_a_fwd_cycles", 32'(fwd_cycles), 0);
        sig_a = 1'b0; sig_b = 1'b0; tick(4);

        // B leads by 12, then coincident edges
        clr_log();
        sig_b = 1'b1; tick(12); sig_a = 1'b1; tick(8);
        sig_a = 1'b0; sig_b = 1'b0; tick(4);
        sig_a = 1'b1; sig_b = 1'b1; tick(8);
        check("lead_b_count", 32'(log_err.size()), 2);
        check_strobe("lead_b", 0, -12, 1'b0);
        check_strobe("coincident", 1, 0, 1'b0);
        check("lead_b_fwd_cycles", 32'(fwd_cycles), 12);
        check("lead_b_slow_cycles", 32'(slow_cycles), 0);
        sig_a = 1'b0; sig_b = 1'b0; tick(4);

        // Timeout with B static
        clr_log();
        sig_a = 1'b1; tick(140);
        check("timeout_count", 32'(log_err.size()), 1);
        check_strobe("timeout", 0, ERR_MAX, 1'b1);
        check("timeout_slow_cycles", 32'(slow_cycles), ERR_MAX);
        sig_a = 1'b0; tick(4);

        // Slip: A twice 20 cycles apart, B 3 cycles after the second A
        clr_log();
        sig_a = 1'b1; tick(5); sig_a = 1'b0; tick(15);
        sig_a = 1'b1; tick(3); sig_b = 1'b1; tick(8);
        check("slip_count", 32'(log_err.size()), 2);
        check_strobe("slip", 0, ERR_MAX, 1'b1);
        check_strobe("slip_close", 1, 3, 1'b0);
        sig_a = 1'b0; sig_b = 1'b0; tick(4);

        // Enable dropped mid-window, then a fresh 7-cycle pair
        clr_log();
        sig_a = 1'b1; tick(7); enable = 1'b0; tick(2); sig_b = 1'b1; tick(8);
        @(negedge clk);
        check("dis_strobes", 32'(log_err.size()), 0);
        check("dis_leads", 32'({fwd, slow}), 0);
        sig_a = 1'b0; sig_b = 1'b0; tick(5);
        enable = 1'b1; tick(2);
        clr_log();
        sig_a = 1'b1; tick(7); sig_b = 1'b1; tick(8);
        check("reen_count", 32'(log_err.size()), 1);
        check_strobe("reen", 0, 7, 1'b0);
        sig_a = 1'b0; sig_b = 1'b0; tick(4);

        // Reset mid-window aborts without a strobe
        clr_log();
        sig_a = 1'b1; tick(6); reset_n = 1'b0; tick(1); sig_a = 1'b0; tick(2);
        reset_n = 1'b1; tick(10);
        check("rst_mid_strobes", 32'(log_err.size()), 0);

        // Randomised segments with varying edge density, enables and rare resets
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 2))
                0: p = 2;
                1: p = 10;
                default: p = 40;
            endcase
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 19) == 0) begin p = 0; len = $urandom_range(150, 200); end
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0; tick(2); reset_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 99) < p) sig_a = ~sig_a;
                if ($urandom_range(0, 99) < p) sig_b = ~sig_b;
                tick(1);
            end
        end
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
